fp32_log2e_prescale: RTL and testbench

Pipelined FP32 scaler that computes y = x · log2(e). It sits directly upstream of the `_2_power_X` unit, so the pair evaluates e^x = 2^(x·log2e) for the softmax/exp path. Its `Result`/`vld_out` drive the downstream `Oprand_A`/`vld_in` without glue logic. It uses the same `en`/`vld` pipeline discipline as its consumer.

---
 rtl/fpu_pkg.sv | 28 ++
 rtl/fp32_log2e_prescale_if.sv | 14 +
 rtl/dff_en.sv | 22 ++
 rtl/fp32_log2e_prescale.sv | 92 +++++++++
 tb/tb_fp32_log2e_prescale.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/fpu_pkg.sv
// Shared FP32 constants and pipeline payload types for the log2(e) prescaler.
package fpu_pkg;

    localparam logic [31:0] LOG2E_F32 = 32'h3FB8AA3B;
    localparam logic [23:0] LOG2E_SIG = 24'hB8AA3B;
    localparam logic [31:0] F32_QNAN  = 32'h7FC00000;
    localparam logic [31:0] F32_PINF  = 32'h7F800000;
    localparam int          F32_BIAS  = 127;

    typedef struct packed {
        logic        sign;
        logic [7:0]  expo;
        logic [22:0] mant;
        logic        is_zero;
        logic        is_inf;
        logic        is_nan;
    } d0_t;

    typedef struct packed {
        logic        sign;
        logic [7:0]  expo;
        logic [47:0] prod;
        logic        is_zero;
        logic        is_inf;
        logic        is_nan;
    } d1_t;

endpackage

// File: rtl/fp32_log2e_prescale_if.sv
// Operand/result bundle between the producer, the prescaler and the exp2 unit.
interface fp32_log2e_prescale_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  vld_in;
    logic [DATA_WIDTH-1:0] Oprand_A;
    logic [DATA_WIDTH-1:0] Result;
    logic                  vld_out;

    // vld_in qualifies Oprand_A on an enabled edge; vld_out qualifies Result.
    // There is no backpressure: the shared en input stalls the whole pipeline.
    modport master (output vld_in, Oprand_A, input Result, vld_out);
    modport slave  (input vld_in, Oprand_A, output Result, vld_out);
endinterface

// File: rtl/dff_en.sv
// Enabled register with asynchronous active-low clear; every pipeline flop uses it.
module dff_en #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] q_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else if (en) begin
            q_q <= d;
        end
    end

    assign q = q_q;
endmodule

// File: rtl/fp32_log2e_prescale.sv
// Three-stage FP32 multiply by log2(e): decode, 24x24 multiply, normalize/round.
module fp32_log2e_prescale
    import fpu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int EXPO_WIDTH = 8,
    parameter int MANT_WIDTH = 23
) (
    input logic                   clk,
    input logic                   rst_n,
    input logic                   en,
    fp32_log2e_prescale_if.slave  io
);
    logic            v0_q, v1_q, vo_q;
    d0_t             d0_d, d0_q;
    d1_t             d1_d, d1_q;
    logic [31:0]     res_d, res_q;

    logic [22:0]     sig;
    logic            guard, sticky, rnd_up;
    logic [23:0]     mant_r;
    logic [8:0]      exp9;

    always_comb begin
        d0_d         = '0;
        d0_d.sign    = io.Oprand_A[DATA_WIDTH-1];
        d0_d.expo    = io.Oprand_A[MANT_WIDTH +: EXPO_WIDTH];
        d0_d.mant    = io.Oprand_A[MANT_WIDTH-1:0];
        d0_d.is_zero = (d0_d.expo == 8'h00);
        d0_d.is_inf  = (d0_d.expo == 8'hFF) && (d0_d.mant == '0);
        d0_d.is_nan  = (d0_d.expo == 8'hFF) && (d0_d.mant != '0);
    end

    always_comb begin
        d1_d         = '0;
        d1_d.sign    = d0_q.sign;
        d1_d.expo    = d0_q.expo;
        d1_d.prod    = 48'({1'b1, d0_q.mant}) * 48'(LOG2E_SIG);
        d1_d.is_zero = d0_q.is_zero;
        d1_d.is_inf  = d0_q.is_inf;
        d1_d.is_nan  = d0_q.is_nan;
    end

    // Product of two [1,2) significands lies in [1,4); bit 47 picks the shift.
    always_comb begin
        sig    = '0;
        guard  = 1'b0;
        sticky = 1'b0;
        exp9   = {1'b0, d1_q.expo};
        if (d1_q.prod[47]) begin
            sig    = d1_q.prod[46:24];
            guard  = d1_q.prod[23];
            sticky = |d1_q.prod[22:0];
            exp9   = {1'b0, d1_q.expo} + 9'd1;
        end else begin
            sig    = d1_q.prod[45:23];
            guard  = d1_q.prod[22];
            sticky = |d1_q.prod[21:0];
        end
        rnd_up = guard & (sticky | sig[0]);
        mant_r = {1'b0, sig} + {23'd0, rnd_up};
        if (mant_r[23]) begin
            exp9 = exp9 + 9'd1;
        end

        res_d = {d1_q.sign, exp9[7:0], mant_r[22:0]};
        if (d1_q.is_nan) begin
            res_d = F32_QNAN;
        end else if (d1_q.is_inf) begin
            res_d = {d1_q.sign, F32_PINF[30:0]};
        end else if (d1_q.is_zero) begin
            res_d = {d1_q.sign, 31'd0};
        end else if (exp9 >= 9'd255) begin
            res_d = {d1_q.sign, F32_PINF[30:0]};
        end
    end

    dff_en #(.WIDTH(1)) u_v0 (.clk(clk), .rst_n(rst_n), .en(en), .d(io.vld_in), .q(v0_q));
    dff_en #(.WIDTH(1)) u_v1 (.clk(clk), .rst_n(rst_n), .en(en), .d(v0_q),      .q(v1_q));
    dff_en #(.WIDTH(1)) u_vo (.clk(clk), .rst_n(rst_n), .en(en), .d(v1_q),      .q(vo_q));

    // Data only advances with a valid token so bubbles leave Result untouched.
    dff_en #(.WIDTH($bits(d0_t))) u_d0 (
        .clk(clk), .rst_n(rst_n), .en(en & io.vld_in), .d(d0_d), .q(d0_q));
    dff_en #(.WIDTH($bits(d1_t))) u_d1 (
        .clk(clk), .rst_n(rst_n), .en(en & v0_q), .d(d1_d), .q(d1_q));
    dff_en #(.WIDTH(32)) u_res (
        .clk(clk), .rst_n(rst_n), .en(en & v1_q), .d(res_d), .q(res_q));

    assign io.Result  = res_q;
    assign io.vld_out = vo_q;
endmodule

// File: tb/tb_fp32_log2e_prescale.sv
// Bench for fp32_log2e_prescale: directed test-plan steps plus randomized traffic
// scored against a real-arithmetic reference of x*log2(e).
module tb_fp32_log2e_prescale;
    import fpu_pkg::*;

    logic clk;
    logic rst_n;
    logic en;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_q[$];
    int          age_q[$];
    logic        exp_vld;
    logic [31:0] exp_res;

    fp32_log2e_prescale_if #(.DATA_WIDTH(32)) dut_if ();

    fp32_log2e_prescale #(
        .DATA_WIDTH(32), .EXPO_WIDTH(8), .MANT_WIDTH(23)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .io(dut_if)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Rounds the exact product of x and log2(e) to binary32, nearest-even.
    function automatic logic [31:0] ref_model(input logic [31:0] x);
        logic   s;
        int     e, m, ex, b;
        real    v, t, q, r;
        longint qi;
        s = x[31];
        e = int'(x[30:23]);
        m = int'(x[22:0]);
        if (e == 255) return (m != 0) ? F32_QNAN : {s, F32_PINF[30:0]};
        if (e == 0) return {s, 31'd0};
        v  = real'(m + 8388608) * real'(LOG2E_SIG);
        ex = e - F32_BIAS - 46;
        while (v >= 2.0) begin
            v  = v / 2.0;
            ex = ex + 1;
        end
        t  = v * 8388608.0;
        q  = $floor(t);
        r  = t - q;
        qi = longint'(q);
        if (r > 0.5 || (r == 0.5 && qi[0])) qi = qi + 1;
        if (qi == 64'd16777216) begin
            qi = 64'd8388608;
            ex = ex + 1;
        end
        b = ex + F32_BIAS;
        if (b >= 255) return {s, F32_PINF[30:0]};
        return {s, b[7:0], qi[22:0]};
    endfunction

    // driver: apply one cycle of inputs, update the scoreboard, check at negedge
    task automatic tick(input logic e_i, input logic v_i, input logic [31:0] x_i,
                        input logic [31:0] exp_i);
        en              = e_i;
        dut_if.vld_in   = v_i;
        dut_if.Oprand_A = x_i;
        @(posedge clk);
        if (e_i) begin
            foreach (age_q[i]) age_q[i] = age_q[i] - 1;
            exp_vld = 1'b0;
            if (age_q.size() > 0 && age_q[0] == 0) begin
                exp_vld = 1'b1;
                exp_res = exp_q.pop_front();
                void'(age_q.pop_front());
            end
            if (v_i) begin
                exp_q.push_back(exp_i);
                age_q.push_back(2);
            end
        end
        @(negedge clk);
        check("vld_out", {31'd0, dut_if.vld_out}, {31'd0, exp_vld});
        check("Result", dut_if.Result, exp_res);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic clear_sb();
        exp_q.delete();
        age_q.delete();
        exp_vld = 1'b0;
        exp_res = 32'h0;
    endtask

    initial begin
        logic [31:0] x;
        logic        e_r, v_r;
        rst_n = 1'b0;
        en = 1'b0;
        dut_if.vld_in = 1'b0;
        dut_if.Oprand_A = 32'h0;
        clear_sb();
        repeat (2) @(negedge clk);
        check("reset_vld", {31'd0, dut_if.vld_out}, 32'd0);
        check("reset_result", dut_if.Result, 32'h0);
        rst_n = 1'b1;

        // single sample latency
        tick(1'b1, 1'b1, 32'h3F800000, LOG2E_F32);
        idle(4);

        // back-to-back, including normalize-with-carry and round-down
        tick(1'b1, 1'b1, 32'h40000000, 32'h4038AA3B);
        tick(1'b1, 1'b1, 32'hBF800000, 32'hBFB8AA3B);
        tick(1'b1, 1'b1, 32'h3FC00000, 32'h400A7FAC);
        idle(3);

        // special classes and overflow
        tick(1'b1, 1'b1, 32'h7F7FFFFF, 32'h7F800000);
        tick(1'b1, 1'b1, 32'hFF7FFFFF, 32'hFF800000);
        tick(1'b1, 1'b1, 32'h7FC00001, 32'h7FC00000);
        tick(1'b1, 1'b1, 32'h00000001, 32'h00000000);
        tick(1'b1, 1'b1, 32'h80000000, 32'h80000000);
        tick(1'b1, 1'b1, 32'hFF800000, 32'hFF800000);
        idle(3);

        // stall with en low; a vld_in offered while stalled must be ignored
        tick(1'b1, 1'b1, 32'h3F800000, LOG2E_F32);
        tick(1'b1, 1'b0, 32'h0, 32'h0);
        tick(1'b0, 1'b0, 32'h0, 32'h0);
        tick(1'b0, 1'b1, 32'h40000000, 32'h4038AA3B);
        tick(1'b0, 1'b0, 32'h0, 32'h0);
        tick(1'b0, 1'b0, 32'h0, 32'h0);
        idle(3);

        // bubble between two samples
        tick(1'b1, 1'b1, 32'h3F800000, LOG2E_F32);
        tick(1'b1, 1'b0, 32'h0, 32'h0);
        tick(1'b1, 1'b1, 32'h40000000, 32'h4038AA3B);
        idle(3);

        // reset with two samples in flight
        tick(1'b1, 1'b1, 32'h40400000, ref_model(32'h40400000));
        tick(1'b1, 1'b1, 32'hC0A00000, ref_model(32'hC0A00000));
        rst_n = 1'b0;
        #1;
        clear_sb();
        check("midrst_vld", {31'd0, dut_if.vld_out}, 32'd0);
        check("midrst_result", dut_if.Result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);

        // randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 7))
                0: x = {1'($urandom_range(0, 1)), 8'hFF, 23'($urandom)};
                1: x = {1'($urandom_range(0, 1)), 8'h00, 23'($urandom)};
                2: x = {1'($urandom_range(0, 1)), 8'($urandom_range(252, 254)), 23'($urandom)};
                default: x = $urandom;
            endcase
            e_r = ($urandom_range(0, 9) != 0);
            v_r = ($urandom_range(0, 3) != 0);
            tick(e_r, v_r, x, ref_model(x));
        end
        idle(4);
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
